id_ex_pipeline_reg: RTL and testbench
=====================================

Name: id_ex_pipeline_reg

Overview:
- Decode-to-Execute pipeline register of the 5-stage MIPS core.
- Captures decoded control, the three register-file read values (third read feeds WGHT) and the register specifiers each cycle.
- Feeds the Execute datapath and the hazard unit: RsE, RtE, RdE, WriteReg source, MemtoRegE, RegWriteE, ALUControlE.
- Consumes the hazard unit's FlushE to insert bubbles; a StallE input is provided for future multi-cycle EX units.

Parameters:
DATA_WIDTH, 32, width of operand, immediate and PC fields
REG_ADDR_WIDTH, 5, width of register specifiers
ALU_CTRL_WIDTH, 3, width of ALUControl

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears every output
FlushE  in  1  load a bubble this edge (from hazard unit)
StallE  in  1  hold current contents this edge; tie 0 until needed
ValidD  in  1  decode slot holds a real instruction
RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decoded control
ALUControlD  in  ALU_CTRL_WIDTH  decoded ALU op (WGHT = 3'b101)
RD1D, RD2D, RD3D  in  DATA_WIDTH each  register-file reads for Rs, Rt, Rd
SignImmD, PCPlus4D  in  DATA_WIDTH each  immediate, PC+4
RsD, RtD, RdD  in  REG_ADDR_WIDTH each  specifiers
ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered copies
ALUControlE  out  ALU_CTRL_WIDTH  registered
RD1E, RD2E, RD3E, SignImmE, PCPlus4E  out  DATA_WIDTH each  registered
RsE, RtE, RdE  out  REG_ADDR_WIDTH each  registered

Behaviour:
- Single-cycle latency: D-side inputs at edge N appear on E outputs after edge N until the next edge.
- Per-edge priority: reset > FlushE > StallE > load.
- reset: every output 0, including ValidE. ALUControlE=0 is a non-WGHT op.
- FlushE: every output 0. Specifiers are cleared too, so RsE/RtE/RdE=0, which the hazard unit's nonzero guard never forwards from. RegWriteE=MemtoRegE=MemWriteE=0, so the bubble writes nothing.
- StallE (no flush): all outputs hold. StallE and FlushE together: the flush wins.
- load: all fields copied. ValidD=0 also forces every control bit to 0 (RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst), while data and specifier fields still copy.
- RD3E is always captured regardless of op; the Execute stage uses it only when ALUControlE = WGHT.
- No combinational path from any input to any output.
- Reset asserted mid-stream: the next edge yields an all-zero register; the prior contents are discarded.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined: adds outputs BubbleCount (32) and IssueCount (32).
- BubbleCount increments on each edge where FlushE=1 and reset=0.
- IssueCount increments on each load edge with ValidD=1.
- Both counters wrap modulo 2^32 and clear on reset.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - DATA_WIDTH, REG_ADDR_WIDTH, ALU_CTRL_WIDTH defaults.
  - ALU op constants, including WGHT_CODE = 3'b101.
  - A packed struct typedef for the D/E control bundle.
- One sub-module, pipe_field_reg: a parameterised-width register with clk/reset/flush/stall/d/q and the priority above. Instantiate it once for the control bundle, once for the data bundle and once for the specifier bundle.

Test Plan:
- Reset: hold reset 2 cycles with all D inputs 1s -> every E output 0, ValidE=0.
- Load: RegWriteD=1, ALUControlD=3'b101, RD3D=0x0000_00AA, RsD=3, RtD=4, RdD=5, ValidD=1 -> next cycle outputs equal those values; no change before the edge.
- Flush: loaded state, then FlushE=1 with new D values -> RsE=RtE=RdE=0, all controls 0, ValidE=0; BubbleCount +1 when the macro is defined.
- Stall vs flush: StallE=1 for 3 cycles with changing D -> outputs frozen. Then StallE=1 with FlushE=1 -> bubble.
- Invalid decode: ValidD=0, RegWriteD=1, MemWriteD=1, RtD=7 -> RegWriteE=0, MemWriteE=0, RtE=7.
- Back-to-back: 4 consecutive loads with distinct PCPlus4D values 0x4, 0x8, 0xC, 0x10 -> PCPlus4E follows one cycle later each; IssueCount=4 when the macro is defined.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, ALU op codes and control bundle for the ID/EX register
//
// Purpose : defaults and types shared by the Decode-to-Execute pipeline register.
// Contents: DEF_DATA_WIDTH / DEF_REG_ADDR_WIDTH / DEF_ALU_CTRL_WIDTH defaults,
//           ALU op constants (WGHT_CODE = 3'b101), ctrl_flags_t packed control bundle.
package pipeline_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_ALU_CTRL_WIDTH = 3;

    // ALU operation encodings seen on ALUControl.
    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;
    localparam logic [2:0] WGHT_CODE = 3'b101;

    // Single-bit control flags carried from Decode to Execute.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_dst;
    } ctrl_flags_t;

endpackage

// File: rtl/pipe_field_reg.sv
// rtl/pipe_field_reg.sv - parameterised pipeline field register with reset/flush/stall
//
// Purpose : one bundle of pipeline state; priority per edge is reset > flush > stall > load.
// Ports   : clk, reset (sync, active-high), flush (load zeros), stall (hold),
//           d [WIDTH-1:0] next value, q [WIDTH-1:0] registered value.
module pipe_field_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - Decode-to-Execute pipeline register of the 5-stage MIPS core
//
// Purpose : registers decoded control, three register-file reads, immediate, PC+4 and
//           register specifiers; FlushE inserts a bubble, StallE holds contents.
// Ports   : clk, reset (sync, active-high), FlushE, StallE, ValidD,
//           RegWriteD/MemtoRegD/MemWriteD/ALUSrcD/RegDstD, ALUControlD,
//           RD1D/RD2D/RD3D/SignImmD/PCPlus4D, RsD/RtD/RdD  ->  matching *E outputs.
// Option  : PIPE_PERF_CNT_EN adds BubbleCount and IssueCount (32-bit, wrapping).
module id_ex_pipeline_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int ALU_CTRL_WIDTH = DEF_ALU_CTRL_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      FlushE,
    input  logic                      StallE,
    input  logic                      ValidD,
    input  logic                      RegWriteD,
    input  logic                      MemtoRegD,
    input  logic                      MemWriteD,
    input  logic                      ALUSrcD,
    input  logic                      RegDstD,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUControlD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     RD3D,
    input  logic [DATA_WIDTH-1:0]     SignImmD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [REG_ADDR_WIDTH-1:0] RsD,
    input  logic [REG_ADDR_WIDTH-1:0] RtD,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    output logic                      ValidE,
    output logic                      RegWriteE,
    output logic                      MemtoRegE,
    output logic                      MemWriteE,
    output logic                      ALUSrcE,
    output logic                      RegDstE,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     RD3E,
    output logic [DATA_WIDTH-1:0]     SignImmE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [REG_ADDR_WIDTH-1:0] RsE,
    output logic [REG_ADDR_WIDTH-1:0] RtE,
    output logic [REG_ADDR_WIDTH-1:0] RdE
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]               BubbleCount,
    output logic [31:0]               IssueCount
`endif
);

    localparam int FLAGS_W = $bits(ctrl_flags_t);
    localparam int CTRL_W  = FLAGS_W + ALU_CTRL_WIDTH;
    localparam int DATA_W  = 5 * DATA_WIDTH;
    localparam int SPEC_W  = 3 * REG_ADDR_WIDTH;

    ctrl_flags_t       flags_d;
    ctrl_flags_t       flags_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic [SPEC_W-1:0] spec_d;
    logic [SPEC_W-1:0] spec_q;

    // An empty decode slot must never write state, so its control bits are
    // squashed here; data, specifiers and ALUControl still pass through.
    always_comb begin
        flags_d            = '0;
        flags_d.valid      = ValidD;
        flags_d.reg_write  = ValidD & RegWriteD;
        flags_d.mem_to_reg = ValidD & MemtoRegD;
        flags_d.mem_write  = ValidD & MemWriteD;
        flags_d.alu_src    = ValidD & ALUSrcD;
        flags_d.reg_dst    = ValidD & RegDstD;
    end

    assign ctrl_d = {flags_d, ALUControlD};
    // RD3 is captured for every op; Execute only consumes it for WGHT_CODE.
    assign data_d = {RD1D, RD2D, RD3D, SignImmD, PCPlus4D};
    assign spec_d = {RsD, RtD, RdD};

    pipe_field_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .flush (FlushE),
        .stall (StallE),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    pipe_field_reg #(.WIDTH(DATA_W)) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .flush (FlushE),
        .stall (StallE),
        .d     (data_d),
        .q     (data_q)
    );

    // Specifiers clear on flush so the hazard unit's nonzero guard never
    // forwards from a bubble.
    pipe_field_reg #(.WIDTH(SPEC_W)) u_spec_reg (
        .clk   (clk),
        .reset (reset),
        .flush (FlushE),
        .stall (StallE),
        .d     (spec_d),
        .q     (spec_q)
    );

    assign {flags_q, ALUControlE} = ctrl_q;
    assign ValidE    = flags_q.valid;
    assign RegWriteE = flags_q.reg_write;
    assign MemtoRegE = flags_q.mem_to_reg;
    assign MemWriteE = flags_q.mem_write;
    assign ALUSrcE   = flags_q.alu_src;
    assign RegDstE   = flags_q.reg_dst;

    assign {RD1E, RD2E, RD3E, SignImmE, PCPlus4E} = data_q;
    assign {RsE, RtE, RdE}                         = spec_q;

`ifdef PIPE_PERF_CNT_EN
    // Counters follow the same reset > flush > stall > load priority as the register.
    always_ff @(posedge clk) begin
        if (reset) begin
            BubbleCount <= '0;
            IssueCount  <= '0;
        end else if (FlushE) begin
            BubbleCount <= BubbleCount + 32'd1;
        end else if (!StallE && ValidD) begin
            IssueCount  <= IssueCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb/tb_id_ex_pipeline_reg.sv - directed-vector bench for id_ex_pipeline_reg
module tb_id_ex_pipeline_reg;

    logic        clk = 1'b0;
    logic        reset, FlushE, StallE, ValidD;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, RD3D, SignImmD, PCPlus4D;
    logic [4:0]  RsD, RtD, RdD;
    logic        ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, RD3E, SignImmE, PCPlus4E;
    logic [4:0]  RsE, RtE, RdE;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] BubbleCount, IssueCount;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_reg dut (
        .clk         (clk),
        .reset       (reset),
        .FlushE      (FlushE),
        .StallE      (StallE),
        .ValidD      (ValidD),
        .RegWriteD   (RegWriteD),
        .MemtoRegD   (MemtoRegD),
        .MemWriteD   (MemWriteD),
        .ALUSrcD     (ALUSrcD),
        .RegDstD     (RegDstD),
        .ALUControlD (ALUControlD),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .RD3D        (RD3D),
        .SignImmD    (SignImmD),
        .PCPlus4D    (PCPlus4D),
        .RsD         (RsD),
        .RtD         (RtD),
        .RdD         (RdD),
        .ValidE      (ValidE),
        .RegWriteE   (RegWriteE),
        .MemtoRegE   (MemtoRegE),
        .MemWriteE   (MemWriteE),
        .ALUSrcE     (ALUSrcE),
        .RegDstE     (RegDstE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .RD3E        (RD3E),
        .SignImmE    (SignImmE),
        .PCPlus4E    (PCPlus4E),
        .RsE         (RsE),
        .RtE         (RtE),
        .RdE         (RdE)
`ifdef PIPE_PERF_CNT_EN
        ,
        .BubbleCount (BubbleCount),
        .IssueCount  (IssueCount)
`endif
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One rising edge, then return on the falling edge where outputs are sampled
    // and new inputs are driven.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_d(input logic v, input logic rw, input logic mtr, input logic mw,
                         input logic as, input logic rdst, input logic [2:0] aluc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3,
                         input logic [31:0] imm, input logic [31:0] pc4,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ValidD = v; RegWriteD = rw; MemtoRegD = mtr; MemWriteD = mw;
        ALUSrcD = as; RegDstD = rdst; ALUControlD = aluc;
        RD1D = r1; RD2D = r2; RD3D = r3; SignImmD = imm; PCPlus4D = pc4;
        RsD = rs; RtD = rt; RdD = rd;
    endtask

    task automatic check_zero(input string tag);
        check_vec({tag, "_valid"},  {31'd0, ValidE},    32'd0);
        check_vec({tag, "_ctrl"},   {26'd0, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, 1'b0}, 32'd0);
        check_vec({tag, "_aluc"},   {29'd0, ALUControlE}, 32'd0);
        check_vec({tag, "_rd1"},    RD1E, 32'd0);
        check_vec({tag, "_rd2"},    RD2E, 32'd0);
        check_vec({tag, "_rd3"},    RD3E, 32'd0);
        check_vec({tag, "_imm"},    SignImmE, 32'd0);
        check_vec({tag, "_pc4"},    PCPlus4E, 32'd0);
        check_vec({tag, "_spec"},   {17'd0, RsE, RtE, RdE}, 32'd0);
    endtask

    initial begin
        // Reset with every D input driven high.
        reset = 1'b1; FlushE = 1'b1; StallE = 1'b1;
        set_d(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b111,
              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              5'h1F, 5'h1F, 5'h1F);
        step();
        step();
        check_zero("reset");
`ifdef PIPE_PERF_CNT_EN
        check_vec("reset_bubble_cnt", BubbleCount, 32'd0);
        check_vec("reset_issue_cnt",  IssueCount,  32'd0);
`endif

        // Load a WGHT op; nothing may change before the edge.
        reset = 1'b0; FlushE = 1'b0; StallE = 1'b0;
        set_d(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101,
              32'h11, 32'h22, 32'h0000_00AA, 32'h33, 32'h44, 5'd3, 5'd4, 5'd5);
        #1;
        check_vec("preedge_regwrite", {31'd0, RegWriteE}, 32'd0);
        check_vec("preedge_rd3",      RD3E, 32'd0);
        step();
        check_vec("load_valid",    {31'd0, ValidE},    32'd1);
        check_vec("load_regwrite", {31'd0, RegWriteE}, 32'd1);
        check_vec("load_regdst",   {31'd0, RegDstE},   32'd1);
        check_vec("load_memwrite", {31'd0, MemWriteE}, 32'd0);
        check_vec("load_aluc",     {29'd0, ALUControlE}, 32'd5);
        check_vec("load_rd1",      RD1E, 32'h11);
        check_vec("load_rd2",      RD2E, 32'h22);
        check_vec("load_rd3",      RD3E, 32'h0000_00AA);
        check_vec("load_imm",      SignImmE, 32'h33);
        check_vec("load_pc4",      PCPlus4E, 32'h44);
        check_vec("load_rs",       {27'd0, RsE}, 32'd3);
        check_vec("load_rt",       {27'd0, RtE}, 32'd4);
        check_vec("load_rd",       {27'd0, RdE}, 32'd5);

        // Flush over fresh D values.
        FlushE = 1'b1;
        set_d(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010,
              32'h55, 32'h66, 32'h77, 32'h88, 32'h99, 5'd10, 5'd11, 5'd12);
        step();
        check_zero("flush");
`ifdef PIPE_PERF_CNT_EN
        check_vec("flush_bubble_cnt", BubbleCount, 32'd1);
`endif

        // Load state A, then stall three cycles with changing D.
        FlushE = 1'b0;
        set_d(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010,
              32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h100, 5'd1, 5'd2, 5'd3);
        step();
        check_vec("stateA_pc4", PCPlus4E, 32'h100);
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_d(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b110,
                  32'h9000 + i, 32'h9100 + i, 32'h9200 + i, 32'h9300 + i, 32'h200 + i,
                  5'd9, 5'd10, 5'd11);
            step();
            check_vec($sformatf("stall%0d_pc4", i),  PCPlus4E, 32'h100);
            check_vec($sformatf("stall%0d_rd1", i),  RD1E, 32'h1000);
            check_vec($sformatf("stall%0d_rs", i),   {27'd0, RsE}, 32'd1);
            check_vec($sformatf("stall%0d_ctrl", i),
                      {26'd0, ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE},
                      32'b110010);
        end

        // Stall together with flush: the flush wins.
        FlushE = 1'b1;
        step();
        check_zero("stallflush");
`ifdef PIPE_PERF_CNT_EN
        check_vec("stallflush_bubble_cnt", BubbleCount, 32'd2);
`endif

        // Invalid decode slot squashes controls but keeps specifiers.
        FlushE = 1'b0; StallE = 1'b0;
        set_d(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010,
              32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 5'd6, 5'd7, 5'd8);
        step();
        check_vec("inval_valid",    {31'd0, ValidE},    32'd0);
        check_vec("inval_regwrite", {31'd0, RegWriteE}, 32'd0);
        check_vec("inval_memwrite", {31'd0, MemWriteE}, 32'd0);
        check_vec("inval_memtoreg", {31'd0, MemtoRegE}, 32'd0);
        check_vec("inval_rt",       {27'd0, RtE}, 32'd7);
        check_vec("inval_rd2",      RD2E, 32'hA2);

        // Reset mid-stream discards the loaded contents.
        set_d(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001,
              32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 5'd13, 5'd14, 5'd15);
        step();
        check_vec("premid_pc4", PCPlus4E, 32'hB5);
        reset = 1'b1;
        step();
        check_zero("midreset");
        reset = 1'b0;

        // Back-to-back loads: PCPlus4E follows one edge later.
        for (int i = 0; i < 4; i++) begin
            set_d(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010,
                  32'd0, 32'd0, 32'd0, 32'd0, 32'(4 * (i + 1)), 5'd1, 5'd2, 5'd3);
            #1;
            check_vec($sformatf("b2b%0d_prev_pc4", i), PCPlus4E, 32'(4 * i));
            step();
            check_vec($sformatf("b2b%0d_pc4", i), PCPlus4E, 32'(4 * (i + 1)));
        end
`ifdef PIPE_PERF_CNT_EN
        check_vec("b2b_issue_cnt", IssueCount, 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
